ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter. It sends one byte (LED/typematic/reset commands) to a PS/2 keyboard or mouse.
//  It is the write-side partner of the PS/2 scancode receiver and is driven from the ZX-Uno SCANCODE register write.
//  It drives the clock and data lines open-drain (low-enables only) and reports busy/error to KBSTATUS.
//  ps2busy gates the receiver: enable_rcv = ~ps2busy.

---
 rtl/ps2_host_tx_pkg.sv | 47 ++++
 rtl/ps2_host_tx_line_filter.sv | 65 ++++++
 rtl/ps2_host_tx.sv | 207 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// ----------------------------------------------------------------------------
// ps2_host_tx_pkg
// Shared definitions for the PS/2 host-to-device transmitter and its line
// filter: FSM state encoding, frame length, microsecond-to-cycle conversion,
// and the frame-bit / parity helpers.
// ----------------------------------------------------------------------------
package ps2_host_tx_pkg;

  // Transmitter FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } tx_state_t;

  // Data bits 0-7, parity, stop; the start bit is driven during INHIBIT
  localparam int PS2_TX_FRAME_BITS = 10;

  // Whole-MHz clocks only: CLK_HZ / 1e6 * us
  function automatic int us_to_cycles(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

  // Odd parity: the parity bit makes the total number of ones odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Frame bit at position idx: data LSB first, then parity, then stop (1)
  function automatic logic frame_bit(input logic [7:0] d,
                                     input logic       par,
                                     input logic [3:0] idx);
    logic b;
    if (idx < 4'd8) begin
      b = d[idx[2:0]];
    end else if (idx == 4'd8) begin
      b = par;
    end else begin
      b = 1'b1;
    end
    return b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// ----------------------------------------------------------------------------
// ps2_host_tx_line_filter
// Conditions one raw PS/2 pad level: 2-FF synchroniser, then a stability
// filter that only accepts a level change after the synchronised line has
// held the new value for FILTER_LEN consecutive cycles, then a falling-edge
// detector on the filtered level.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous reset, active-high (idle bus level = 1)
//   raw    in  asynchronous pad level
//   level  out filtered line level
//   fall   out one-cycle pulse, the cycle after level went 1 -> 0
// ----------------------------------------------------------------------------
module ps2_host_tx_line_filter
  import ps2_host_tx_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int                CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       sync_r;
  logic [CNT_W-1:0] cnt_r;

  // Two-stage synchroniser for the asynchronous pad
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], raw};
    end
  end

  // Stability filter and falling-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b1;
      cnt_r <= CNT_ZERO;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync_r[1] == level) begin
        // Any return to the accepted level restarts the stability window
        cnt_r <= CNT_ZERO;
      end else if (cnt_r == CNT_LAST) begin
        level <= sync_r[1];
        cnt_r <= CNT_ZERO;
        // level is still the old value here, so 1 means a 1 -> 0 change
        fall  <= level;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter: sends one command byte to a keyboard or
// mouse. The host inhibits the bus, posts a start bit, then shifts data,
// odd parity and stop on the device's falling clock edges, samples the
// device ACK and waits for the bus to go idle. Lines are open-drain: an
// *_oe of 1 pulls the line low, 0 releases it.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   ps2clk_in     raw PS/2 clock pad level (asynchronous)
//   ps2data_in    raw PS/2 data pad level (asynchronous)
//   ps2clk_oe     1 = pull clock low
//   ps2data_oe    1 = pull data low
//   data          byte to send, sampled on an accepted dataload
//   dataload      one-cycle write strobe, accepted only while idle
//   ps2busy       high from the cycle after acceptance until back in IDLE
//   ps2error      sticky NACK/timeout flag, cleared by the next accept
//   done          one-cycle pulse on ACK followed by bus idle
// ----------------------------------------------------------------------------
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_HZ           = 28_000_000,
  parameter int INHIBIT_US       = 120,
  parameter int START_TIMEOUT_US = 15000,
  parameter int BIT_TIMEOUT_US   = 2000,
  parameter int FILTER_LEN       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] data,
  input  logic       dataload,
  output logic       ps2busy,
  output logic       ps2error,
  output logic       done
);

  localparam int INHIBIT_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
  localparam int START_CYC   = us_to_cycles(CLK_HZ, START_TIMEOUT_US);
  localparam int BIT_CYC     = us_to_cycles(CLK_HZ, BIT_TIMEOUT_US);
  localparam int MAX_CYC     = (INHIBIT_CYC > START_CYC) ?
                               ((INHIBIT_CYC > BIT_CYC) ? INHIBIT_CYC : BIT_CYC) :
                               ((START_CYC > BIT_CYC) ? START_CYC : BIT_CYC);
  localparam int TMR_W       = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] TMR_ZERO     = TMR_W'(0);
  localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);
  localparam logic [TMR_W-1:0] INHIBIT_LAST = TMR_W'(INHIBIT_CYC - 1);
  localparam logic [TMR_W-1:0] START_LOAD   = TMR_W'(START_CYC);
  localparam logic [TMR_W-1:0] BIT_LOAD     = TMR_W'(BIT_CYC);
  localparam logic [3:0]       LAST_BIT     = 4'(PS2_TX_FRAME_BITS - 1);

  tx_state_t        state_r;
  logic [7:0]       data_r;
  logic             parity_r;
  logic [3:0]       bitcnt_r;
  logic [TMR_W-1:0] timer_r;
  logic             ack_ok_r;

  logic clk_filt_s;
  logic clk_fall_s;
  logic data_filt_s;
  logic data_fall_unused_s;

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (ps2clk_in),
    .level (clk_filt_s),
    .fall  (clk_fall_s)
  );

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (ps2data_in),
    .level (data_filt_s),
    .fall  (data_fall_unused_s)
  );

  // Transmit FSM with registered line drives and status outputs.
  // timer_r counts down and holds at zero; zero in SEND/ACK/WAIT_IDLE is a
  // timeout. A device fall is checked before the timer so it wins a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      data_r     <= 8'h00;
      parity_r   <= 1'b0;
      bitcnt_r   <= 4'd0;
      timer_r    <= TMR_ZERO;
      ack_ok_r   <= 1'b0;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
      ps2busy    <= 1'b0;
      ps2error   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          ps2clk_oe  <= 1'b0;
          ps2data_oe <= 1'b0;
          ps2busy    <= 1'b0;
          if (dataload) begin
            data_r    <= data;
            parity_r  <= odd_parity(data);
            ps2error  <= 1'b0;
            ps2busy   <= 1'b1;
            ps2clk_oe <= 1'b1;
            ack_ok_r  <= 1'b0;
            bitcnt_r  <= 4'd0;
            timer_r   <= INHIBIT_LAST;
            state_r   <= ST_INHIBIT;
          end
        end

        // Clock held low; device edges here are our own and are ignored
        ST_INHIBIT: begin
          if (timer_r == TMR_ZERO) begin
            ps2clk_oe <= 1'b0;
            state_r   <= ST_REQ;
          end else begin
            timer_r <= timer_r - TMR_ONE;
            // Start bit goes out on the last inhibit cycle
            if (timer_r == TMR_ONE) begin
              ps2data_oe <= 1'b1;
            end
          end
        end

        ST_REQ: begin
          timer_r  <= START_LOAD;
          bitcnt_r <= 4'd0;
          state_r  <= ST_SEND;
        end

        ST_SEND: begin
          if (clk_fall_s) begin
            ps2data_oe <= ~frame_bit(data_r, parity_r, bitcnt_r);
            timer_r    <= BIT_LOAD;
            if (bitcnt_r == LAST_BIT) begin
              state_r <= ST_ACK;
            end else begin
              bitcnt_r <= bitcnt_r + 4'd1;
            end
          end else if (timer_r == TMR_ZERO) begin
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            ps2busy    <= 1'b0;
            ps2error   <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            timer_r <= timer_r - TMR_ONE;
          end
        end

        // Device pulls data low for one clock to acknowledge
        ST_ACK: begin
          if (clk_fall_s) begin
            ack_ok_r <= ~data_filt_s;
            if (data_filt_s) begin
              ps2error <= 1'b1;
            end
            timer_r <= BIT_LOAD;
            state_r <= ST_WAIT_IDLE;
          end else if (timer_r == TMR_ZERO) begin
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            ps2busy    <= 1'b0;
            ps2error   <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            timer_r <= timer_r - TMR_ONE;
          end
        end

        ST_WAIT_IDLE: begin
          if (clk_filt_s && data_filt_s) begin
            ps2busy <= 1'b0;
            done    <= ack_ok_r;
            state_r <= ST_IDLE;
          end else if (timer_r == TMR_ZERO) begin
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            ps2busy    <= 1'b0;
            ps2error   <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            timer_r <= timer_r - TMR_ONE;
          end
        end

        default: begin
          ps2clk_oe  <= 1'b0;
          ps2data_oe <= 1'b0;
          ps2busy    <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_tx
// Bench for ps2_host_tx with a behavioural PS/2 device on a wired-AND bus.
// Timeouts are shortened (150 us start, 50 us bit) so the run stays short;
// the 120 us inhibit keeps its real 3360-cycle length at 28 MHz.
// ----------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INHIBIT_CYC = 3360;
  localparam int START_CYC   = 4200;
  localparam int BIT_CYC     = 1400;
  localparam int HALF        = 40;
  localparam int START_DLY   = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2clk_in;
  logic       ps2data_in;
  logic       ps2clk_oe;
  logic       ps2data_oe;
  logic [7:0] data = 8'h00;
  logic       dataload = 1'b0;
  logic       ps2busy;
  logic       ps2error;
  logic       done;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  assign ps2clk_in  = ~(ps2clk_oe | dev_clk_low);
  assign ps2data_in = ~(ps2data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ           (28_000_000),
    .INHIBIT_US       (120),
    .START_TIMEOUT_US (150),
    .BIT_TIMEOUT_US   (50),
    .FILTER_LEN       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2clk_in  (ps2clk_in),
    .ps2data_in (ps2data_in),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .data       (data),
    .dataload   (dataload),
    .ps2busy    (ps2busy),
    .ps2error   (ps2error),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Scoreboard entry: byte, hand-computed parity, expected error/done, frame check
  typedef struct packed {
    logic [7:0] b;
    logic       par;
    logic       err;
    logic       dn;
    logic       chk;
  } exp_t;
  exp_t sb[$];

  // Device model: 0 = ACK, 1 = NACK, 2 = never clocks, 3 = stops after bit 3
  int         dev_mode     = 0;
  logic       dev_glitch   = 1'b0;
  logic       dev_active   = 1'b0;
  int         dev_fall_cnt = 0;
  int         dev_last_fall = 0;
  logic [9:0] rx_frame     = 10'h000;
  int         rx_n         = 0;

  initial begin : device
    forever begin
      @(negedge clk);
      while (!ps2clk_oe) @(negedge clk);
      while (ps2clk_oe) @(negedge clk);
      dev_active   = 1'b1;
      dev_fall_cnt = 0;
      rx_n         = 0;
      rx_frame     = 10'h000;
      if (dev_mode != 2) begin
        repeat (START_DLY) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          if (dev_mode == 3 && i == 4) break;
          dev_clk_low   = 1'b1;
          dev_fall_cnt++;
          dev_last_fall = cyc;
          repeat (HALF) @(negedge clk);
          dev_clk_low = 1'b0;
          rx_frame[i] = ps2data_in;
          rx_n++;
          if (dev_glitch && i == 4) begin
            repeat (HALF / 2) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (3) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF / 2 - 3) @(negedge clk);
          end else begin
            repeat (HALF) @(negedge clk);
          end
        end
        if (dev_mode != 3) begin
          dev_data_low = (dev_mode != 1);
          repeat (HALF / 2) @(negedge clk);
          dev_clk_low = 1'b1;
          repeat (HALF) @(negedge clk);
          dev_clk_low = 1'b0;
          repeat (HALF / 2) @(negedge clk);
          dev_data_low = 1'b0;
        end
      end
      dev_active = 1'b0;
    end
  end

  // Monitor: accumulates per-transfer observations and scores at busy fall
  int   n_done = 0;
  int   inhib_cnt = 0;
  int   both_cnt = 0;
  int   busy_len = 0;
  int   last_busy_len = 0;
  int   end_cyc = 0;
  logic prev_busy = 1'b0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) n_done++;
      if (ps2busy) busy_len++;
      if (ps2clk_oe) inhib_cnt++;
      if (ps2clk_oe && ps2data_oe) both_cnt++;
      if (prev_busy && !ps2busy) begin
        end_cyc       = cyc;
        last_busy_len = busy_len;
        if (sb.size() == 0) begin
          check("unexpected_xfer_end", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("error_flag", {31'd0, ps2error}, {31'd0, e.err});
          check("done_pulses", n_done, {31'd0, e.dn});
          check("inhibit_cycles", inhib_cnt, INHIBIT_CYC);
          check("start_bit_cycles", both_cnt, 32'd1);
          if (e.chk) begin
            check("frame_bits", {22'd0, rx_frame}, {22'd0, 1'b1, e.par, e.b});
            check("frame_len", rx_n, 32'd10);
          end
        end
        n_done    = 0;
        inhib_cnt = 0;
        both_cnt  = 0;
        busy_len  = 0;
      end
      prev_busy = ps2busy;
    end
  end

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] b, input logic par, input logic err,
                      input logic dn, input logic chk);
    exp_t e;
    e.b = b; e.par = par; e.err = err; e.dn = dn; e.chk = chk;
    sb.push_back(e);
  endtask

  task automatic do_load(input logic [7:0] b);
    @(negedge clk);
    data     = b;
    dataload = 1'b1;
    @(negedge clk);
    dataload = 1'b0;
    data     = 8'h00;
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (ps2busy && k < 20000) begin @(negedge clk); k++; end
    check("xfer_finished", {31'd0, ps2busy}, 32'd0);
    k = 0;
    while (dev_active && k < 5000) begin @(negedge clk); k++; end
    repeat (30) @(negedge clk);
  endtask

  task automatic wait_falls(input int n);
    int k;
    k = 0;
    while (!(dev_active && dev_fall_cnt >= n) && k < 10000) begin @(negedge clk); k++; end
    check("device_reached_fall", {31'd0, (dev_active && dev_fall_cnt >= n)}, 32'd1);
  endtask

  initial begin : stimulus
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_clk_oe", {31'd0, ps2clk_oe}, 32'd0);
    check("rst_data_oe", {31'd0, ps2data_oe}, 32'd0);
    check("rst_busy", {31'd0, ps2busy}, 32'd0);
    check("rst_error", {31'd0, ps2error}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    // ED: bits 1,0,1,1,0,1,1,1, parity 1
    push(8'hED, 1'b1, 1'b0, 1'b1, 1'b1);
    do_load(8'hED);
    check("busy_after_accept", {31'd0, ps2busy}, 32'd1);
    wait_end();

    push(8'hF4, 1'b0, 1'b0, 1'b1, 1'b1);
    do_load(8'hF4);
    wait_end();
    push(8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    do_load(8'h00);
    wait_end();

    // NACK, then the next accept clears the sticky error
    dev_mode = 1;
    push(8'hED, 1'b1, 1'b1, 1'b0, 1'b1);
    do_load(8'hED);
    wait_end();
    dev_mode = 0;
    check("error_sticky", {31'd0, ps2error}, 32'd1);
    push(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
    do_load(8'hFF);
    check("error_cleared", {31'd0, ps2error}, 32'd0);
    wait_end();

    // Load during SEND is ignored; a 3-cycle clock glitch adds no bit
    dev_glitch = 1'b1;
    push(8'hED, 1'b1, 1'b0, 1'b1, 1'b1);
    do_load(8'hED);
    wait_falls(3);
    do_load(8'h55);
    wait_end();
    dev_glitch = 1'b0;

    // Device never clocks: start timeout after inhibit
    dev_mode = 2;
    push(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    do_load(8'h3C);
    wait_end();
    check_range("start_timeout_len", last_busy_len,
                INHIBIT_CYC + START_CYC, INHIBIT_CYC + START_CYC + 4);
    check("timeout_clk_released", {31'd0, ps2clk_oe}, 32'd0);
    check("timeout_data_released", {31'd0, ps2data_oe}, 32'd0);

    // Device stops after bit 3: bit timeout after its last fall
    dev_mode = 3;
    push(8'hED, 1'b1, 1'b1, 1'b0, 1'b0);
    do_load(8'hED);
    wait_end();
    check_range("bit_timeout_gap", end_cyc - dev_last_fall, BIT_CYC, BIT_CYC + 40);
    dev_mode = 0;

    // Reset with bit 4 (a 0) on the bus
    push(8'hED, 1'b1, 1'b0, 1'b0, 1'b0);
    do_load(8'hED);
    wait_falls(5);
    repeat (20) @(negedge clk);
    check("pre_rst_data_driven", {31'd0, ps2data_oe}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_clk_oe", {31'd0, ps2clk_oe}, 32'd0);
    check("midrst_data_oe", {31'd0, ps2data_oe}, 32'd0);
    check("midrst_busy", {31'd0, ps2busy}, 32'd0);
    check("midrst_error", {31'd0, ps2error}, 32'd0);
    wait_end();

    push(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
    do_load(8'hA5);
    wait_end();

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
